// File: rtl/fifo_d_drain_if.sv
// fifo_d_drain_if: bundles the d0/d1 FIFO pop-side signals and the egress
// stream of fifo_d_drain.
//   master : the drain block (drives pops and the output stream)
//   slave  : the surrounding FIFOs / egress logic
// Signals:
//   fifo_empty_d0/d1  FIFO empty flags
//   data_out_0/1      FIFO read data, valid the cycle after the pop
//   fifo_error_d0/d1  FIFO error flags
//   pause_out         downstream almost-full
//   pop_d0/d1         pop strobes (combinational)
//   data_out          registered output word
//   valid_out         data_out valid
//   src_out           source of data_out (0=d0, 1=d1)
//   err_out           sticky error
interface fifo_d_drain_if #(
  parameter int unsigned DATA_SIZE = 6
);
  logic                 fifo_empty_d0;
  logic                 fifo_empty_d1;
  logic [DATA_SIZE-1:0] data_out_0;
  logic [DATA_SIZE-1:0] data_out_1;
  logic                 fifo_error_d0;
  logic                 fifo_error_d1;
  logic                 pause_out;
  logic                 pop_d0;
  logic                 pop_d1;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 src_out;
  logic                 err_out;

  modport master (
    input  fifo_empty_d0, fifo_empty_d1, data_out_0, data_out_1,
           fifo_error_d0, fifo_error_d1, pause_out,
    output pop_d0, pop_d1, data_out, valid_out, src_out, err_out
  );

  modport slave (
    output fifo_empty_d0, fifo_empty_d1, data_out_0, data_out_1,
           fifo_error_d0, fifo_error_d1, pause_out,
    input  pop_d0, pop_d1, data_out, valid_out, src_out, err_out
  );
endinterface

// File: rtl/fifo_d_drain.sv
// fifo_d_drain: pop-side consumer for the d0/d1 per-class FIFOs. Drains both
// into one registered stream using weighted round-robin bursts (up to
// BURST_D0 / BURST_D1 consecutive pops while the other FIFO has data),
// honours a downstream pause and keeps a sticky error flag.
// Ports:
//   clk    single clock, posedge
//   reset  asynchronous, active-high
//   bus    fifo_d_drain_if.master (FIFO flags/data in, pops and stream out)
// Read latency is fixed at 2 cycles: pop in k -> valid_out in k+2.
module fifo_d_drain #(
  parameter int unsigned DATA_SIZE = 6,
  parameter int unsigned BURST_D0  = 4,
  parameter int unsigned BURST_D1  = 4,
  parameter int unsigned BCNT_W    = 3
) (
  input  logic           clk,
  input  logic           reset,
  fifo_d_drain_if.master bus
);

  typedef enum logic [1:0] {IDLE, GNT_D0, GNT_D1} state_t;

  localparam logic [BCNT_W-1:0] LAST_D0 = BCNT_W'(BURST_D0 - 1);
  localparam logic [BCNT_W-1:0] LAST_D1 = BCNT_W'(BURST_D1 - 1);

  state_t               state;
  logic [BCNT_W-1:0]    burst_cnt;
  logic                 last_src;
  logic                 pend_valid;
  logic                 pend_src;
  logic [DATA_SIZE-1:0] data_q;
  logic                 valid_q;
  logic                 src_q;
  logic                 err_q;
  logic                 pop0;
  logic                 pop1;

  // Pops depend only on the grant, the empty flag and pause; the state is
  // forced to IDLE asynchronously, so both strobes drop with reset.
  assign pop0 = (state == GNT_D0) && !bus.fifo_empty_d0 && !bus.pause_out;
  assign pop1 = (state == GNT_D1) && !bus.fifo_empty_d1 && !bus.pause_out;

  assign bus.pop_d0    = pop0;
  assign bus.pop_d1    = pop1;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.src_out   = src_q;
  assign bus.err_out   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      burst_cnt  <= '0;
      last_src   <= 1'b1;
      pend_valid <= 1'b0;
      pend_src   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      src_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // Read pipeline: stage 1 remembers which FIFO was popped, stage 2
      // captures that FIFO's read data once it is valid.
      pend_valid <= pop0 || pop1;
      pend_src   <= pop1;
      valid_q    <= pend_valid;
      if (pend_valid) begin
        data_q <= pend_src ? bus.data_out_1 : bus.data_out_0;
        src_q  <= pend_src;
      end

      if (bus.fifo_error_d0 || bus.fifo_error_d1) begin
        err_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          burst_cnt <= '0;
          // d0 wins if non-empty and either preferred (last was d1) or d1 is empty.
          if (!bus.fifo_empty_d0 && (last_src || bus.fifo_empty_d1)) begin
            state <= GNT_D0;
          end else if (!bus.fifo_empty_d1) begin
            state <= GNT_D1;
          end
        end

        GNT_D0: begin
          if (pop0) begin
            if (burst_cnt == LAST_D0 && !bus.fifo_empty_d1) begin
              state     <= GNT_D1;
              burst_cnt <= '0;
              last_src  <= 1'b0;
            end else if (burst_cnt != LAST_D0) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else if (bus.fifo_empty_d0) begin
            burst_cnt <= '0;
            last_src  <= 1'b0;
            state     <= bus.fifo_empty_d1 ? IDLE : GNT_D1;
          end
        end

        GNT_D1: begin
          if (pop1) begin
            if (burst_cnt == LAST_D1 && !bus.fifo_empty_d0) begin
              state     <= GNT_D0;
              burst_cnt <= '0;
              last_src  <= 1'b1;
            end else if (burst_cnt != LAST_D1) begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end else if (bus.fifo_empty_d1) begin
            burst_cnt <= '0;
            last_src  <= 1'b1;
            state     <= bus.fifo_empty_d0 ? IDLE : GNT_D0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
